// File: rtl/anime_pkg.sv
// Shared codes for sprite pose sequencing: ghost states, directions,
// mouth FSM states and pose base values.
package anime_pkg;

    localparam logic [3:0] G_IDLE       = 4'd0;
    localparam logic [3:0] G_CHASE      = 4'd1;
    localparam logic [3:0] G_SCATTER    = 4'd2;
    localparam logic [3:0] G_FRIGHTENED = 4'd3;
    localparam logic [3:0] G_DIE        = 4'd4;

    localparam logic [1:0] DIR_R = 2'd0;
    localparam logic [1:0] DIR_L = 2'd1;
    localparam logic [1:0] DIR_U = 2'd2;
    localparam logic [1:0] DIR_D = 2'd3;

    typedef enum logic [1:0] {
        M_WIDE,
        M_HALF,
        M_CLOSED,
        M_HALF2
    } mouth_state_t;

    localparam int POSE_FRIGHT = 8;
    localparam int POSE_FLASH  = 10;
    localparam int POSE_EYES   = 12;
    localparam int POSE_DEATH  = 16;

    function automatic logic [1:0] mouth_code(input mouth_state_t m);
        logic [1:0] c;
        c = 2'd0;
        unique case (1'b1)
            (m == M_WIDE):                    c = 2'd0;
            (m == M_HALF) || (m == M_HALF2):  c = 2'd1;
            (m == M_CLOSED):                  c = 2'd2;
            default:                          c = 2'd0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/anime_tick_div.sv
// Frame-tick divider: counts ticks 0..DIV-1 and flags the wrapping tick.
// The wrap flag is combinational so it lines up with the tick that causes it.
module anime_tick_div #(
    parameter int DIV = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_clr,
    output logic o_wrap
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    assign o_wrap = i_tick && !i_clr && (cnt == LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (i_clr) begin
            cnt <= '0;
        end else if (i_tick) begin
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/sprite_pose_sequencer.sv
// Per-pixel pose select for Pac-Man and ghosts with frame-driven animation.
// Optional death animation enabled by defining PACMAN_DEATH_ANIM_EN.
module sprite_pose_sequencer
    import anime_pkg::*;
#(
    parameter int NUM_GHOSTS = 4,
    parameter int ANIM_DIV   = 8,
    parameter int FLASH_DIV  = 16,
    parameter int POSE_W     = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_frame_tick,
    input  logic [3:0]              i_which_char,
    input  logic [1:0]              i_pacman_direction,
    input  logic                    i_pacman_moving,
    input  logic [4*NUM_GHOSTS-1:0] i_ghost_state,
    input  logic [2*NUM_GHOSTS-1:0] i_ghost_direction,
    input  logic                    i_fright_ending,
`ifdef PACMAN_DEATH_ANIM_EN
    input  logic                    i_pacman_dying,
`endif
    output logic [POSE_W-1:0]       o_pacman_pose,
    output logic [POSE_W-1:0]       o_ghost_pose,
    output logic                    o_anim_phase
);

    logic         step_pulse;
    logic         flash_wrap;
    logic         phase;
    logic         flash_on;
    logic         dying_fall;
    mouth_state_t mouth;
    mouth_state_t mouth_nx;
    logic [POSE_W-1:0] pac_c;
    logic [POSE_W-1:0] ghost_c;
    logic         g_hit;
    logic [3:0]   g_state;
    logic [1:0]   g_dir;

    anime_tick_div #(.DIV(ANIM_DIV)) u_step (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tick  (i_frame_tick),
        .i_clr   (1'b0),
        .o_wrap  (step_pulse)
    );

    anime_tick_div #(.DIV(FLASH_DIV)) u_flash (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_tick  (i_frame_tick),
        .i_clr   (!i_fright_ending),
        .o_wrap  (flash_wrap)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            phase    <= 1'b0;
            flash_on <= 1'b0;
        end else begin
            if (step_pulse) phase <= ~phase;
            if (!i_fright_ending) flash_on <= 1'b0;
            else if (flash_wrap) flash_on <= ~flash_on;
        end
    end

`ifdef PACMAN_DEATH_ANIM_EN
    logic       dying_q;
    logic       dying_rise;
    logic [3:0] death_cnt;

    assign dying_rise = i_pacman_dying && !dying_q;
    assign dying_fall = !i_pacman_dying && dying_q;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            dying_q   <= 1'b0;
            death_cnt <= '0;
        end else begin
            dying_q <= i_pacman_dying;
            if (dying_rise || dying_fall) death_cnt <= '0;
            else if (i_pacman_dying && step_pulse && death_cnt != 4'd11)
                death_cnt <= death_cnt + 4'd1;
        end
    end
`else
    assign dying_fall = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) mouth <= M_WIDE;
        else          mouth <= mouth_nx;
    end

    always_comb begin
        mouth_nx = mouth;
        if (dying_fall) begin
            mouth_nx = M_WIDE;
        end else if (step_pulse && i_pacman_moving) begin
            unique case (mouth)
                M_WIDE:   mouth_nx = M_HALF;
                M_HALF:   mouth_nx = M_CLOSED;
                M_CLOSED: mouth_nx = M_HALF2;
                M_HALF2:  mouth_nx = M_WIDE;
                default:  mouth_nx = M_WIDE;
            endcase
        end
    end

    always_comb begin
        pac_c = POSE_W'({i_pacman_direction, mouth_code(mouth)});
`ifdef PACMAN_DEATH_ANIM_EN
        if (i_pacman_dying)
            pac_c = POSE_W'(POSE_DEATH) + POSE_W'(death_cnt);
`endif
    end

    // Out-of-range selects leave g_hit low so the ghost pose reads 0.
    always_comb begin
        g_hit   = 1'b0;
        g_state = '0;
        g_dir   = '0;
        for (int k = 0; k < NUM_GHOSTS; k++) begin
            if (i_which_char == 4'(k + 1)) begin
                g_hit   = 1'b1;
                g_state = i_ghost_state[4*k +: 4];
                g_dir   = i_ghost_direction[2*k +: 2];
            end
        end
    end

    always_comb begin
        ghost_c = '0;
        if (g_hit) begin
            case (g_state)
                G_IDLE, G_CHASE, G_SCATTER:
                    ghost_c = POSE_W'({g_dir, phase});
                G_FRIGHTENED:
                    ghost_c = POSE_W'(flash_on ? POSE_FLASH : POSE_FRIGHT)
                            + POSE_W'(phase);
                G_DIE:
                    ghost_c = POSE_W'(POSE_EYES) + POSE_W'(g_dir);
                default:
                    ghost_c = '0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_pacman_pose <= '0;
            o_ghost_pose  <= '0;
        end else begin
            o_pacman_pose <= pac_c;
            o_ghost_pose  <= ghost_c;
        end
    end

    assign o_anim_phase = phase;

endmodule

// File: tb/tb_sprite_pose_sequencer.sv
// Randomized bench for sprite_pose_sequencer against a frame/step-count model.
// Covers the death animation when PACMAN_DEATH_ANIM_EN is defined.
module tb_sprite_pose_sequencer;

    localparam int NG = 4;
    localparam int AD = 8;
    localparam int FD = 16;
    localparam int PW = 5;
    localparam int NCYC = 6000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic [3:0]    which_char = '0;
    logic [1:0]    pdir = '0;
    logic          moving = 1'b0;
    logic [4*NG-1:0] gstate = '0;
    logic [2*NG-1:0] gdir = '0;
    logic          ending = 1'b0;
    logic          dying = 1'b0;
    logic [PW-1:0] pac_pose;
    logic [PW-1:0] ghost_pose;
    logic          anim_phase;

    sprite_pose_sequencer #(
        .NUM_GHOSTS (NG),
        .ANIM_DIV   (AD),
        .FLASH_DIV  (FD),
        .POSE_W     (PW)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_frame_tick       (frame_tick),
        .i_which_char       (which_char),
        .i_pacman_direction (pdir),
        .i_pacman_moving    (moving),
        .i_ghost_state      (gstate),
        .i_ghost_direction  (gdir),
        .i_fright_ending    (ending),
`ifdef PACMAN_DEATH_ANIM_EN
        .i_pacman_dying     (dying),
`endif
        .o_pacman_pose      (pac_pose),
        .o_ghost_pose       (ghost_pose),
        .o_anim_phase       (anim_phase)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: frames counted modulo the divider, steps counted absolutely,
    // mouth as an index into its cyclic code table.
    int tick_cnt, steps, mouth_idx, flash_cnt, death_cnt;
    bit flash, dying_prev;
    int mouth_tab [4] = '{0, 1, 2, 1};
    int exp_pac, exp_ghost;

    function automatic int ghost_model(int wc, int st, int dir, int ph, bit fl);
        if (wc < 1 || wc > NG) return 0;
        case (st)
            0, 1, 2: return dir * 2 + ph;
            3:       return (fl ? 10 : 8) + ph;
            4:       return 12 + dir;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        tick_cnt = 0; steps = 0; mouth_idx = 0;
        flash_cnt = 0; flash = 0; death_cnt = 0; dying_prev = 0;
    endtask

    task automatic model_predict();
        int wc, st, dr;
        wc = int'(which_char);
        st = 0;
        dr = 0;
        if (wc >= 1 && wc <= NG) begin
            st = int'(gstate[4*(wc-1) +: 4]);
            dr = int'(gdir[2*(wc-1) +: 2]);
        end
        exp_ghost = ghost_model(wc, st, dr, steps % 2, flash);
`ifdef PACMAN_DEATH_ANIM_EN
        if (dying) exp_pac = 16 + death_cnt;
        else exp_pac = int'(pdir) * 4 + mouth_tab[mouth_idx];
`else
        exp_pac = int'(pdir) * 4 + mouth_tab[mouth_idx];
`endif
    endtask

    task automatic model_advance();
        bit step;
        bit fall;
        step = frame_tick && (tick_cnt == AD - 1);
        if (frame_tick) tick_cnt = (tick_cnt + 1) % AD;
        if (step) steps++;
`ifdef PACMAN_DEATH_ANIM_EN
        fall = dying_prev && !dying;
`else
        fall = 0;
`endif
        if (fall) mouth_idx = 0;
        else if (step && moving) mouth_idx = (mouth_idx + 1) % 4;
        if (!ending) begin
            flash_cnt = 0;
            flash = 0;
        end else if (frame_tick) begin
            flash_cnt++;
            if (flash_cnt == FD) begin
                flash_cnt = 0;
                flash = !flash;
            end
        end
        if (dying != dying_prev) death_cnt = 0;
        else if (dying && step && death_cnt < 11) death_cnt++;
        dying_prev = dying;
    endtask

    task automatic drive_random();
        frame_tick = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 9) == 0) which_char = 4'($urandom_range(5, 15));
        else which_char = 4'($urandom_range(0, 4));
        pdir   = 2'($urandom_range(0, 3));
        moving = ($urandom_range(0, 7) != 0);
        for (int k = 0; k < NG; k++) begin
            if ($urandom_range(0, 7) == 0) gstate[4*k +: 4] = 4'($urandom_range(5, 15));
            else gstate[4*k +: 4] = 4'($urandom_range(0, 4));
            gdir[2*k +: 2] = 2'($urandom_range(0, 3));
        end
        if ($urandom_range(0, 59) == 0) ending = !ending;
`ifdef PACMAN_DEATH_ANIM_EN
        if ($urandom_range(0, 299) == 0) dying = !dying;
`endif
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_pac", int'(pac_pose), 0);
        check("reset_ghost", int'(ghost_pose), 0);
        check("reset_phase", int'(anim_phase), 0);
        rst_n = 1'b1;
        exp_pac = 0;
        exp_ghost = 0;
        for (int cyc = 0; cyc < NCYC; cyc++) begin
            @(negedge clk);
            check("pac_pose", int'(pac_pose), exp_pac);
            check("ghost_pose", int'(ghost_pose), exp_ghost);
            check("anim_phase", int'(anim_phase), steps % 2);
            if (cyc == NCYC / 2) begin
                rst_n = 1'b0;
                #1;
                check("midrst_pac", int'(pac_pose), 0);
                check("midrst_ghost", int'(ghost_pose), 0);
                check("midrst_phase", int'(anim_phase), 0);
                model_reset();
                dying = 1'b0;
                rst_n = 1'b1;
            end
            drive_random();
            model_predict();
            model_advance();
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
